qsys_traffic_master: RTL and testbench

//  Parametrised Avalon-MM traffic master. Successor to the single-word qsys_master.

---
 rtl/qsys_traffic_master.sv | 122 ++++++++++++
 tb/tb_qsys_traffic_master.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qsys_traffic_master.sv
// Avalon-MM traffic master: writes NUM_TXN tagged words, reads them back with
// up to MAX_PENDING reads outstanding and counts every mismatching or spurious response.
module qsys_traffic_master #(
    parameter int     WIDTH       = 32,
    parameter int     ADDR_WIDTH  = 32,
    parameter int     ID          = 0,
    parameter int     DST_ID      = 1,
    parameter int     NUM_TXN     = 16,
    parameter int     MAX_PENDING = 4,
    parameter longint BASE_ADDR   = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  done,
    output logic                  error,
    output logic [15:0]           err_count,
    output logic [WIDTH-1:0]      writedata,
    output logic [ADDR_WIDTH-1:0] address,
    output logic                  write,
    output logic                  read,
    input  logic [WIDTH-1:0]      readdata,
    input  logic                  readdatavalid,
    input  logic                  waitrequest
);
    localparam int CW = WIDTH - 16;
    localparam int PW = $clog2(MAX_PENDING + 1);
    localparam logic [CW-1:0] LAST = CW'(NUM_TXN - 1);
    localparam logic [PW-1:0] PMAX = PW'(MAX_PENDING);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WRITE  = 3'd1;
    localparam logic [2:0] S_READ   = 3'd2;
    localparam logic [2:0] S_DRAIN  = 3'd3;
    localparam logic [2:0] S_FINISH = 3'd4;

    logic [2:0]    state;
    logic [CW-1:0] wi;
    logic [CW-1:0] ri;
    logic [CW-1:0] ci;
    logic [PW-1:0] pending;
    logic          acc_wr;
    logic          acc_rd;
    logic          spurious;
    logic          matched_rsp;
    logic          mismatch;

    function automatic logic [WIDTH-1:0] pattern(input logic [CW-1:0] i);
        return {8'(ID), 8'(DST_ID), i};
    endfunction

    function automatic logic [ADDR_WIDTH-1:0] addr(input logic [CW-1:0] i);
        return ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(i) * ADDR_WIDTH'(WIDTH / 8);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] c);
        return (c == 16'hFFFF) ? c : c + 16'd1;
    endfunction

    // Bus outputs are decoded from registered state only, so a stall holds them
    // stable and readdatavalid never reaches read combinationally.
    always_comb begin
        write     = (state == S_WRITE);
        read      = (state == S_READ) && (pending < PMAX);
        done      = (state == S_FINISH);
        writedata = '0;
        address   = '0;
        if (state == S_WRITE) begin
            writedata = pattern(wi);
            address   = addr(wi);
        end else if (state == S_READ) begin
            address = addr(ri);
        end
    end

    assign acc_wr      = write && !waitrequest;
    assign acc_rd      = read && !waitrequest;
    assign spurious    = readdatavalid && (pending == '0) && !acc_rd;
    assign matched_rsp = readdatavalid && !spurious;
    assign mismatch    = matched_rsp && (readdata != pattern(ci));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            wi        <= '0;
            ri        <= '0;
            ci        <= '0;
            pending   <= '0;
            error     <= 1'b0;
            err_count <= '0;
        end else begin
            pending <= pending + PW'(acc_rd) - PW'(matched_rsp);
            if (matched_rsp) begin
                ci <= ci + CW'(1);
            end
            if (spurious || mismatch) begin
                error     <= 1'b1;
                err_count <= sat_inc(err_count);
            end
            case (state)
                S_IDLE: state <= S_WRITE;
                S_WRITE: begin
                    if (acc_wr) begin
                        wi <= wi + CW'(1);
                        if (wi == LAST) state <= S_READ;
                    end
                end
                S_READ: begin
                    if (acc_rd) begin
                        ri <= ri + CW'(1);
                        if (ri == LAST) state <= S_DRAIN;
                    end
                end
                S_DRAIN: begin
                    // A lost response parks the block here until reset.
                    if (pending == '0) state <= S_FINISH;
                end
                S_FINISH: state <= S_FINISH;
                default:  state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_qsys_traffic_master.sv
// Bench for qsys_traffic_master: behavioural Avalon slave plus a scoreboard monitor
// that checks every accepted write/read against the expected index sequence.
module tb_qsys_traffic_master;
    localparam int NUM  = 16;
    localparam int MAXP = 4;
    localparam int BASE = 0;

    logic        clk = 1'b0;
    logic        rst;
    logic        done, error;
    logic [15:0] err_count;
    logic [31:0] writedata, address, readdata;
    logic        write, read, readdatavalid, waitrequest;

    always #5 clk = ~clk;

    qsys_traffic_master #(
        .WIDTH(32), .ADDR_WIDTH(32), .ID(0), .DST_ID(1),
        .NUM_TXN(NUM), .MAX_PENDING(MAXP), .BASE_ADDR(BASE)
    ) dut (
        .clk(clk), .rst(rst), .done(done), .error(error), .err_count(err_count),
        .writedata(writedata), .address(address), .write(write), .read(read),
        .readdata(readdata), .readdatavalid(readdatavalid), .waitrequest(waitrequest)
    );

    typedef struct { logic [31:0] a; logic [31:0] d; } wr_t;
    typedef struct { int due; logic [31:0] d; } rsp_t;

    int n_tests = 0;
    int n_fail  = 0;

    // Slave configuration, set by the main sequence before each run.
    int wmode      = 0;
    int fixed_lat  = 1;
    bit flip_word  = 0;
    bit spur_pend  = 0;

    logic [31:0] mem [NUM];
    rsp_t        rsp_q[$];
    int          cyc = 0;
    int          last_due = 0;

    wr_t         exp_wr[$];
    logic [31:0] exp_rd[$];
    int          outst = 0;
    int          max_out = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          first_wr = 0;
    int          last_wr = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", nm, act, exp);
        end
    endtask

    task automatic fail_now(input string nm, input logic [63:0] act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0h, want none", nm, act);
    endtask

    // Behavioural slave: decides waitrequest and responses at the falling edge.
    initial begin
        int ix, lat, due;
        logic [31:0] d;
        forever begin
            @(negedge clk);
            cyc++;
            readdatavalid = 1'b0;
            readdata      = '0;
            if (rst) begin
                rsp_q.delete();
                waitrequest = 1'b0;
                last_due    = 0;
            end else begin
                if (rsp_q.size() > 0 && rsp_q[0].due <= cyc) begin
                    readdatavalid = 1'b1;
                    readdata      = rsp_q[0].d;
                    void'(rsp_q.pop_front());
                end else if (spur_pend && write) begin
                    readdatavalid = 1'b1;
                    readdata      = $urandom;
                    spur_pend     = 0;
                end
                case (wmode)
                    0:       waitrequest = 1'b0;
                    1:       waitrequest = (cyc % 3 != 2);
                    default: waitrequest = ($urandom_range(0, 3) == 0);
                endcase
                ix = int'((address - 32'(BASE)) >> 2);
                if (write && !waitrequest && ix >= 0 && ix < NUM) mem[ix] = writedata;
                if (read && !waitrequest) begin
                    lat = (fixed_lat == 0) ? int'($urandom_range(1, 8)) : fixed_lat;
                    due = cyc + lat;
                    if (due <= last_due) due = last_due + 1;
                    last_due = due;
                    d = (ix >= 0 && ix < NUM) ? mem[ix] : 32'h0;
                    if (flip_word && ix == 3) d = d ^ 32'h1;
                    rsp_q.push_back('{due, d});
                end
            end
        end
    end

    // Scoreboard monitor: pops the expected transaction for every accepted request.
    initial begin
        bit acc_wr, acc_rd;
        wr_t e;
        logic [31:0] ea;
        forever begin
            @(negedge clk);
            #1;
            if (rst) begin
                exp_wr.delete();
                exp_rd.delete();
                outst = 0;
            end else begin
                acc_wr = write && !waitrequest;
                acc_rd = read && !waitrequest;
                if (read || write) chk("rd_wr_exclusive", {read, write}, {1'b0, 1'b0} | {read & ~write, write & ~read});
                if (outst >= MAXP) chk("read_at_max_pending", read, 0);
                if (acc_wr) begin
                    if (exp_wr.size() == 0) fail_now("extra_write", address);
                    else begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", address, e.a);
                        chk("wr_data", writedata, e.d);
                    end
                    if (wr_cnt == 0) first_wr = cyc;
                    last_wr = cyc;
                    wr_cnt++;
                end
                if (acc_rd) begin
                    if (exp_rd.size() == 0) fail_now("extra_read", address);
                    else begin
                        ea = exp_rd.pop_front();
                        chk("rd_addr", address, ea);
                    end
                    rd_cnt++;
                end
                if (readdatavalid && !(outst == 0 && !acc_rd)) outst--;
                if (acc_rd) outst++;
                if (outst > max_out) max_out = outst;
            end
        end
    end

    task automatic reset_pulse(input bit check);
        @(posedge clk); #2;
        rst = 1'b1;
        @(posedge clk); #2;
        if (check) begin
            chk("rst_done", done, 0);
            chk("rst_error", error, 0);
            chk("rst_err_count", err_count, 0);
            chk("rst_write", write, 0);
            chk("rst_read", read, 0);
            chk("rst_writedata", writedata, 0);
            chk("rst_address", address, 0);
        end
        rst = 1'b0;
        wr_cnt  = 0;
        rd_cnt  = 0;
        max_out = 0;
        for (int i = 0; i < NUM; i++) begin
            exp_wr.push_back('{32'(BASE + i * 4), {8'h00, 8'h01, 16'(i)}});
            exp_rd.push_back(32'(BASE + i * 4));
        end
    endtask

    task automatic start(input int wm, input int lat, input bit flip, input bit spur);
        wmode     = wm;
        fixed_lat = lat;
        flip_word = flip;
        spur_pend = spur;
        reset_pulse(0);
    endtask

    task automatic finish_run(input int exp_err, input string nm);
        bit got = 0;
        for (int k = 0; k < 4000 && !got; k++) begin
            @(negedge clk); #2;
            if (done) got = 1;
        end
        chk({nm, "_done"}, done, 1);
        repeat (4) @(negedge clk);
        #2;
        chk({nm, "_err_count"}, err_count, exp_err);
        chk({nm, "_error"}, error, (exp_err != 0));
        chk({nm, "_writes"}, wr_cnt, NUM);
        chk({nm, "_reads"}, rd_cnt, NUM);
        chk({nm, "_wr_left"}, exp_wr.size(), 0);
        chk({nm, "_rd_left"}, exp_rd.size(), 0);
        chk({nm, "_done_sticky"}, done, 1);
    endtask

    initial begin
        bit found;
        rst = 1'b1;
        waitrequest = 1'b0;
        readdatavalid = 1'b0;
        readdata = '0;
        repeat (2) @(posedge clk);
        #2;
        chk("init_done", done, 0);
        chk("init_error", error, 0);
        chk("init_err_count", err_count, 0);
        chk("init_write", write, 0);
        chk("init_read", read, 0);

        start(0, 1, 0, 0);
        finish_run(0, "ideal");
        chk("ideal_consecutive_writes", last_wr - first_wr, NUM - 1);

        start(1, 1, 0, 0);
        finish_run(0, "stall110");
        chk("stall110_mem5", mem[5], 32'h0001_0005);

        start(0, 6, 0, 0);
        finish_run(0, "lat6");
        chk("lat6_max_pending", max_out, MAXP);

        start(0, 1, 1, 0);
        finish_run(1, "flip3");

        start(0, 1, 0, 1);
        finish_run(1, "spurious");

        start(0, 6, 0, 0);
        found = 0;
        for (int k = 0; k < 500 && !found; k++) begin
            @(negedge clk); #2;
            if (outst == 2) found = 1;
        end
        chk("midrst_two_pending", found, 1);
        reset_pulse(1);
        finish_run(0, "midrst_rerun");

        for (int r = 0; r < 3; r++) begin
            start(2, 0, 0, 0);
            finish_run(0, "random");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
